// File: rtl/lcv_mul_wide_seq_if.sv
// Request/result bundle for the wide sequential multiplier.
// The slave side is the multiplier; the master side is issue logic plus writeback.
interface lcv_mul_wide_seq_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
);
    logic                   inp_valid;
    logic                   inp_ready;
    logic [WIDTH-1:0]       inp_a;
    logic [WIDTH-1:0]       inp_b;
    logic                   inp_signed;
    logic [TAG_WIDTH-1:0]   inp_tag;
    logic                   outp_valid;
    logic                   outp_ready;
    logic [2*WIDTH-1:0]     outp_prod;
    logic [TAG_WIDTH-1:0]   outp_tag;
    logic                   outp_busy;

    modport slave (
        input  inp_valid, inp_a, inp_b, inp_signed, inp_tag, outp_ready,
        output inp_ready, outp_valid, outp_prod, outp_tag, outp_busy
    );

    modport master (
        output inp_valid, inp_a, inp_b, inp_signed, inp_tag, outp_ready,
        input  inp_ready, outp_valid, outp_prod, outp_tag, outp_busy
    );
endinterface

// File: rtl/lcv_mul_wide_seq.sv
// WIDTH x WIDTH -> 2*WIDTH multiplier built from four HALF x HALF unsigned
// partial products on one mul-acc datapath; sign handled by magnitude/negate.
module lcv_mul_wide_seq #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    lcv_mul_wide_seq_if.slave   bus
);
    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_phase;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_prod;
    logic [WIDTH-1:0]       r_mag_a;
    logic [WIDTH-1:0]       r_mag_b;
    logic                   r_neg;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [TAG_WIDTH-1:0]   r_otag;
    logic                   r_valid;

    logic                   w_ready;
    logic                   w_accept;
    logic [HALF-1:0]        w_op_x;
    logic [HALF-1:0]        w_op_y;
    logic [WIDTH-1:0]       w_pp;
    logic [2*WIDTH-1:0]     w_addend;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    assign w_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept = bus.inp_valid && w_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_MUL;  else w_state_nxt = S_IDLE;
            S_MUL:   if (r_phase == 2'd3) w_state_nxt = S_FIX; else w_state_nxt = S_MUL;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  if (bus.outp_ready) w_state_nxt = S_IDLE; else w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase bit 1 picks the a half, bit 0 the b half: aL.bL, aL.bH, aH.bL, aH.bH.
    always_comb begin
        w_op_x   = r_phase[1] ? r_mag_a[WIDTH-1:HALF] : r_mag_a[HALF-1:0];
        w_op_y   = r_phase[0] ? r_mag_b[WIDTH-1:HALF] : r_mag_b[HALF-1:0];
        w_pp     = WIDTH'(w_op_x) * WIDTH'(w_op_y);
        w_addend = {{WIDTH{1'b0}}, w_pp};
        case (r_phase)
            2'd0:    w_addend = {{WIDTH{1'b0}}, w_pp};
            2'd1:    w_addend = {{WIDTH{1'b0}}, w_pp} << HALF;
            2'd2:    w_addend = {{WIDTH{1'b0}}, w_pp} << HALF;
            2'd3:    w_addend = {w_pp, {WIDTH{1'b0}}};
            default: w_addend = {{WIDTH{1'b0}}, w_pp};
        endcase
    end

    // Operand capture, accumulation, sign fix-up and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 2'd0;
            r_acc   <= {(2*WIDTH){1'b0}};
            r_prod  <= {(2*WIDTH){1'b0}};
            r_mag_a <= {WIDTH{1'b0}};
            r_mag_b <= {WIDTH{1'b0}};
            r_neg   <= 1'b0;
            r_tag   <= {TAG_WIDTH{1'b0}};
            r_otag  <= {TAG_WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag_a <= magnitude(bus.inp_a, bus.inp_signed);
                        r_mag_b <= magnitude(bus.inp_b, bus.inp_signed);
                        r_neg   <= bus.inp_signed && (bus.inp_a[WIDTH-1] ^ bus.inp_b[WIDTH-1]);
                        r_tag   <= bus.inp_tag;
                        r_acc   <= {(2*WIDTH){1'b0}};
                        r_phase <= 2'd0;
                    end
                end
                S_MUL: begin
                    r_acc   <= r_acc + w_addend;
                    r_phase <= r_phase + 2'd1;
                end
                S_FIX: begin
                    r_prod  <= r_neg ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
                    r_otag  <= r_tag;
                    r_valid <= 1'b1;
                end
                S_DONE: begin
                    if (bus.outp_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign bus.inp_ready  = w_ready;
    assign bus.outp_valid = r_valid;
    assign bus.outp_prod  = r_prod;
    assign bus.outp_tag   = r_otag;
    assign bus.outp_busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_lcv_mul_wide_seq.sv
// Directed bench for lcv_mul_wide_seq: hand-computed products, latency,
// output backpressure and reset in the middle of an operation.
module tb_lcv_mul_wide_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    lcv_mul_wide_seq_if #(.WIDTH(32), .TAG_WIDTH(4)) bus ();

    lcv_mul_wide_seq #(.WIDTH(32), .TAG_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [3:0] t, input logic [63:0] exp, input int stall);
        int w;
        int lat;
        w = 0;
        while (!bus.inp_ready && w < 20) begin
            step();
            w = w + 1;
        end
        chk("ready_before_req", 64'(bus.inp_ready), 64'd1);
        bus.inp_a      = a;
        bus.inp_b      = b;
        bus.inp_signed = s;
        bus.inp_tag    = t;
        bus.inp_valid  = 1'b1;
        step();
        bus.inp_valid  = 1'b0;
        bus.inp_a      = ~a;
        bus.inp_b      = ~b;
        bus.inp_signed = ~s;
        bus.inp_tag    = ~t;
        lat = 0;
        while (!bus.outp_valid && lat < 20) begin
            step();
            lat = lat + 1;
        end
        chk("latency", 64'(lat), 64'd5);
        chk("prod", bus.outp_prod, exp);
        chk("tag", 64'(bus.outp_tag), 64'(t));
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_valid", 64'(bus.outp_valid), 64'd1);
            chk("stall_prod", bus.outp_prod, exp);
            chk("stall_tag", 64'(bus.outp_tag), 64'(t));
            chk("stall_ready", 64'(bus.inp_ready), 64'd0);
        end
        bus.outp_ready = 1'b1;
        step();
        bus.outp_ready = 1'b0;
        chk("valid_drop", 64'(bus.outp_valid), 64'd0);
        chk("ready_after", 64'(bus.inp_ready), 64'd1);
    endtask

    // Directed stimulus sequence.
    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst            = 1'b1;
        bus.inp_valid  = 1'b0;
        bus.inp_a      = 32'd0;
        bus.inp_b      = 32'd0;
        bus.inp_signed = 1'b0;
        bus.inp_tag    = 4'd0;
        bus.outp_ready = 1'b0;
        step();
        step();
        chk("rst_ready_low", 64'(bus.inp_ready), 64'd0);
        chk("rst_valid", 64'(bus.outp_valid), 64'd0);
        chk("rst_busy", 64'(bus.outp_busy), 64'd0);
        chk("rst_prod", bus.outp_prod, 64'd0);
        chk("rst_tag", 64'(bus.outp_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_high", 64'(bus.inp_ready), 64'd1);

        run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h3, 64'hFFFF_FFFE_0000_0001, 3);
        run_req(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 4'h5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        run_req(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 4'h6, 64'h0000_0004_FFFF_FFF1, 0);
        run_req(32'h8000_0000, 32'h8000_0000, 1'b1, 4'h7, 64'h4000_0000_0000_0000, 0);
        run_req(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 4'h8, 64'h0000_0000_0000_0000, 0);
        run_req(32'h0001_0000, 32'h0001_0000, 1'b0, 4'h9, 64'h0000_0001_0000_0000, 0);
        run_req(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 4'hA, 64'h0000_FFFE_0001_0000, 1);
        run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'hB, 64'h0000_0000_0000_0001, 0);

        // Reset while the MUL state is on phase 2.
        bus.inp_a      = 32'h1234_5678;
        bus.inp_b      = 32'h9ABC_DEF0;
        bus.inp_signed = 1'b0;
        bus.inp_tag    = 4'hC;
        bus.inp_valid  = 1'b1;
        step();
        bus.inp_valid  = 1'b0;
        step();
        step();
        chk("mid_busy", 64'(bus.outp_busy), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 64'(bus.outp_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.outp_busy), 64'd0);
        chk("mid_rst_prod", bus.outp_prod, 64'd0);
        chk("mid_rst_tag", 64'(bus.outp_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.inp_ready), 64'd1);
        run_req(32'd7, 32'd6, 1'b0, 4'hD, 64'd42, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
